// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] HALT_WORD        = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target arithmetic for the fetch stage.
// PC_ALIGN_CHECK_EN: when defined, the jump-register target keeps its low
// bits and a misalignment flag is produced; otherwise the low bits are cleared.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] instr_pc_i,
    input  logic [15:0]     branch_offset_i,
    input  logic [25:0]     jump_index_i,
    input  logic [XLEN-1:0] jump_reg_addr_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic [XLEN-1:0] jump_target_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic            jreg_misaligned_o,
`endif
    output logic [XLEN-1:0] jreg_target_o
);

    logic [XLEN-1:0] branch_disp;

    // Word-scaled, sign-extended branch displacement.
    assign branch_disp     = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
    assign pc_plus4_o      = instr_pc_i + XLEN'(PC_STEP);
    assign branch_target_o = pc_plus4_o + branch_disp;
    assign jump_target_o   = {pc_plus4_o[31:28], jump_index_i, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign jreg_target_o     = jump_reg_addr_i;
    assign jreg_misaligned_o = |jump_reg_addr_i[1:0];
`else
    assign jreg_target_o     = jump_reg_addr_i & ~XLEN'(3);
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencing ahead of the instruction memory.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned jump-register targets
// raise a sticky align_err and halt fetch instead of redirecting.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_index,
    input  logic            jump_reg,
    input  logic [XLEN-1:0] jump_reg_addr,
    input  logic            halt_req,
    output logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            halted,
    output logic            align_err
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            valid_q;

    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] jreg_target;
    logic            redirect_c;
    logic [XLEN-1:0] target_c;

`ifdef PC_ALIGN_CHECK_EN
    logic            jreg_misaligned;
    logic            align_err_q;
`endif

    pc_target_calc u_target_calc (
        .instr_pc_i        (instr_pc_q),
        .branch_offset_i   (branch_offset),
        .jump_index_i      (jump_index),
        .jump_reg_addr_i   (jump_reg_addr),
        .pc_plus4_o        (pc_plus4),
        .branch_target_o   (branch_target),
        .jump_target_o     (jump_target),
`ifdef PC_ALIGN_CHECK_EN
        .jreg_misaligned_o (jreg_misaligned),
`endif
        .jreg_target_o     (jreg_target)
    );

    // Redirect selection below halt: jump-register, jump, then branch.
    always_comb begin
        redirect_c = 1'b0;
        target_c   = pc_q;
        if (jump_reg) begin
            redirect_c = 1'b1;
            target_c   = jreg_target;
        end else if (jump) begin
            redirect_c = 1'b1;
            target_c   = jump_target;
        end else if (branch_taken) begin
            redirect_c = 1'b1;
            target_c   = branch_target;
        end
    end

    // Fetch sequencer: boot, run with one-slot squash on redirect, absorbing halt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    pc_q       <= RESET_PC + XLEN'(PC_STEP);
                    instr_pc_q <= RESET_PC;
                    valid_q    <= 1'b1;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (valid_q && halt_req) begin
                            valid_q <= 1'b0;
                            state_q <= HALT;
`ifdef PC_ALIGN_CHECK_EN
                        end else if (valid_q && jump_reg && jreg_misaligned) begin
                            align_err_q <= 1'b1;
                            valid_q     <= 1'b0;
                            state_q     <= HALT;
`endif
                        end else if (valid_q && redirect_c) begin
                            pc_q       <= target_c;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b0;
                        end else begin
                            pc_q       <= pc_q + XLEN'(PC_STEP);
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    // Replay the in-flight address while stalled so the memory re-latches it.
    assign fetch_addr  = (stall && (state_q == RUN)) ? instr_pc_q : pc_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALT);
`ifdef PC_ALIGN_CHECK_EN
    assign align_err   = align_err_q;
`else
    assign align_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected correct-path PCs are queued
// by the stimulus and popped by a monitor on every consumed fetch slot.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_addr;
    logic        halt_req;
    logic [31:0] fetch_addr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;
    logic        align_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    bit          mon_en  = 1'b0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jump_reg_addr (jump_reg_addr),
        .halt_req      (halt_req),
        .fetch_addr    (fetch_addr),
        .instr_pc      (instr_pc),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .align_err     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns at posedge+1 once the given PC is presented as a valid word.
    task automatic wait_pc(input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (instr_valid === 1'b1 && instr_pc === pc) found = 1'b1;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pc: instr_pc %h never became valid", pc);
        end
    endtask

    // Monitor: every slot decode consumes must match the next queued PC.
    always @(negedge clk) begin
        if (mon_en && reset === 1'b1 && instr_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid_slot", instr_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_instr_pc", instr_pc, e);
                chk("sb_pc_plus4", pc_plus4, e + 32'd4);
            end
        end
    end

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0;
        jump          = 1'b0;
        jump_index    = 26'h0;
        jump_reg      = 1'b0;
        jump_reg_addr = 32'h0;
        halt_req      = 1'b0;

        // Boot, stall at 0x8, jump at 0x20 to 0x18, branch at 0x1C to 0x24, halt at 0x24.
        exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
        exp_q.push_back(32'h0C); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
        exp_q.push_back(32'h18); exp_q.push_back(32'h1C); exp_q.push_back(32'h20);
        exp_q.push_back(32'h18); exp_q.push_back(32'h1C); exp_q.push_back(32'h24);
        mon_en = 1'b1;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_addr", fetch_addr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_align_err", 32'(align_err), 32'h0);

        reset = 1'b1;
        #1;
        chk("boot_fetch_addr", fetch_addr, 32'h0);
        chk("boot_valid", 32'(instr_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("first_valid", 32'(instr_valid), 32'h1);
        chk("first_instr_pc", instr_pc, 32'h0);
        chk("first_fetch_addr", fetch_addr, 32'h4);

        // Stall two cycles at 0x8.
        wait_pc(32'h08);
        stall = 1'b1;
        #1;
        chk("stall_fetch_addr", fetch_addr, 32'h08);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("stall_instr_pc", instr_pc, 32'h08);
            chk("stall_valid", 32'(instr_valid), 32'h1);
            chk("stall_fetch_addr_hold", fetch_addr, 32'h08);
        end
        stall = 1'b0;
        #1;
        chk("unstall_fetch_addr", fetch_addr, 32'h0C);

        // Jump wins over a simultaneous branch.
        wait_pc(32'h20);
        jump          = 1'b1;
        jump_index    = 26'h6;
        branch_taken  = 1'b1;
        branch_offset = 16'h0001;
        @(posedge clk);
        #1;
        jump         = 1'b0;
        branch_taken = 1'b0;
        chk("jump_squash_valid", 32'(instr_valid), 32'h0);
        chk("jump_squash_pc", instr_pc, 32'h24);
        chk("jump_target", fetch_addr, 32'h18);

        // Taken branch at 0x1C, offset +1 word.
        wait_pc(32'h1C);
        branch_taken  = 1'b1;
        branch_offset = 16'h0001;
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        chk("branch_squash_valid", 32'(instr_valid), 32'h0);
        chk("branch_target", fetch_addr, 32'h24);

        // Halt requested under stall: stall wins, halt taken once it drops.
        wait_pc(32'h24);
        stall    = 1'b1;
        halt_req = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_halt_not_halted", 32'(halted), 32'h0);
        chk("stall_halt_valid", 32'(instr_valid), 32'h1);
        chk("stall_halt_pc", instr_pc, 32'h24);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("halted", 32'(halted), 32'h1);
        chk("halt_valid", 32'(instr_valid), 32'h0);
        chk("halt_instr_pc", instr_pc, 32'h24);
        chk("halt_fetch_addr", fetch_addr, 32'h28);

        // Halt is absorbing even with stall and redirects asserted.
        halt_req     = 1'b0;
        stall        = 1'b1;
        branch_taken = 1'b1;
        jump         = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_halted", 32'(halted), 32'h1);
            chk("hold_valid", 32'(instr_valid), 32'h0);
            chk("hold_instr_pc", instr_pc, 32'h24);
            chk("hold_fetch_addr", fetch_addr, 32'h28);
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;

        // Reset out of HALT returns to BOOT.
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rehalt_rst_halted", 32'(halted), 32'h0);
        chk("rehalt_rst_valid", 32'(instr_valid), 32'h0);
        chk("rehalt_rst_fetch_addr", fetch_addr, 32'h0);
        chk("rehalt_rst_instr_pc", instr_pc, 32'h0);

        exp_q.push_back(32'h00);
        exp_q.push_back(32'h04);
`ifndef PC_ALIGN_CHECK_EN
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
`endif
        reset = 1'b1;

        // Misaligned jump-register at 0x4, outranking a simultaneous jump.
        wait_pc(32'h04);
        jump_reg      = 1'b1;
        jump_reg_addr = 32'h12;
        jump          = 1'b1;
        jump_index    = 26'h20;
        @(posedge clk);
        #1;
        jump_reg = 1'b0;
        jump     = 1'b0;
        chk("jr_valid", 32'(instr_valid), 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("jr_align_err", 32'(align_err), 32'h1);
        chk("jr_halted", 32'(halted), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("jr_align_err_sticky", 32'(align_err), 32'h1);
`else
        chk("jr_align_err", 32'(align_err), 32'h0);
        chk("jr_halted", 32'(halted), 32'h0);
        chk("jr_target", fetch_addr, 32'h10);
`endif

        // Drain the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
